// File: rtl/led_effect_pkg.sv
// Shared types for the LED effect sequencer: effect modes, FSM state codes
// and bounce direction codes.
package led_effect_pkg;

   typedef enum logic [1:0] {
      SHIFT_ONCE = 2'd0,
      ROTATE     = 2'd1,
      BOUNCE     = 2'd2,
      FILL       = 2'd3
   } mode_e;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   localparam logic DIR_UP = 1'b0;
   localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/led_period_timer.sv
// Down-counting step timer: ticks while enabled when the count reaches zero,
// then reloads the value captured at load time.
module led_period_timer #(
   parameter int CNT_W = 25
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             en_i,
   output logic             tick_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] reload_q, reload_d;

   assign tick_o = en_i && (cnt_q == '0);

   always_comb begin
      cnt_d    = cnt_q;
      reload_d = reload_q;
      if (load_i) begin
         cnt_d    = load_val_i;
         reload_d = load_val_i;
      end else if (tick_o) begin
         cnt_d = reload_q;
      end else if (en_i) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q    <= '0;
         reload_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         reload_q <= reload_d;
      end
   end

endmodule

// File: rtl/led_effect_seq.sv
// Single-lit-LED pattern sequencer with four effects, a programmable step
// period and start/stop/done handshakes. All outputs are registered.
module led_effect_seq
   import led_effect_pkg::*;
#(
   parameter int N_LEDS = 8,
   parameter int CNT_W  = 25
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop_req,
   input  logic [1:0]        mode,
   input  logic [CNT_W-1:0]  period,
   output logic [N_LEDS-1:0] leds,
   output logic              busy,
   output logic              done,
   output logic              step_tick
);

   localparam logic [N_LEDS-1:0] LED_LSB = {{(N_LEDS-1){1'b0}}, 1'b1};

   state_t            state_q, state_d;
   mode_e             mode_q, mode_d;
   logic              dir_q, dir_d;
   logic [N_LEDS-1:0] leds_q, leds_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              tick_q, tick_d;

   logic              tmr_load;
   logic              tmr_en;
   logic              tmr_tick;
   logic [CNT_W-1:0]  tmr_load_val;

   // A period of zero is treated as one, so the reload value never underflows.
   assign tmr_load_val = (period == '0) ? '0 : period - 1'b1;
   assign tmr_en       = (state_q == ST_RUN) && !stop_req;

   led_period_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .load_i     (tmr_load),
      .load_val_i (tmr_load_val),
      .en_i       (tmr_en),
      .tick_o     (tmr_tick)
   );

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      dir_d    = dir_q;
      leds_d   = leds_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      tick_d   = 1'b0;
      tmr_load = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_RUN;
               mode_d   = mode_e'(mode);
               dir_d    = DIR_UP;
               leds_d   = LED_LSB;
               busy_d   = 1'b1;
               tmr_load = 1'b1;
            end
         end

         ST_RUN: begin
            // Abort wins over a step landing on the same edge.
            if (stop_req) begin
               leds_d  = '0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_DONE;
            end else if (tmr_tick) begin
               tick_d = 1'b1;
               case (mode_q)
                  SHIFT_ONCE: begin
                     leds_d = leds_q << 1;
                     if (leds_q[N_LEDS-1]) begin
                        leds_d  = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                     end
                  end
                  ROTATE: leds_d = {leds_q[N_LEDS-2:0], leds_q[N_LEDS-1]};
                  BOUNCE: begin
                     if (dir_q == DIR_UP) begin
                        if (leds_q[N_LEDS-1]) begin
                           dir_d  = DIR_DN;
                           leds_d = leds_q >> 1;
                        end else begin
                           leds_d = leds_q << 1;
                        end
                     end else begin
                        if (leds_q[0]) begin
                           dir_d  = DIR_UP;
                           leds_d = leds_q << 1;
                        end else begin
                           leds_d = leds_q >> 1;
                        end
                     end
                  end
                  FILL: begin
                     if (&leds_q) begin
                        leds_d  = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                     end else begin
                        leds_d = {leds_q[N_LEDS-2:0], 1'b1};
                     end
                  end
                  default: leds_d = '0;
               endcase
            end
         end

         ST_DONE: state_d = ST_IDLE;

         default: begin
            state_d = ST_IDLE;
            leds_d  = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         mode_q  <= SHIFT_ONCE;
         dir_q   <= DIR_UP;
         leds_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         dir_q   <= dir_d;
         leds_q  <= leds_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         tick_q  <= tick_d;
      end
   end

   assign leds      = leds_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign step_tick = tick_q;

endmodule

// File: tb/tb_led_effect_seq.sv
// Self-checking bench for led_effect_seq: directed and randomized effect runs
// compared cycle by cycle against an index-based model of the LED patterns.
module tb_led_effect_seq;

   localparam int N     = 8;
   localparam int CNT_W = 25;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic             stop_req = 1'b0;
   logic [1:0]       mode = 2'd0;
   logic [CNT_W-1:0] period = '0;
   logic [N-1:0]     leds;
   logic             busy;
   logic             done;
   logic             step_tick;

   int compared   = 0;
   int mismatched = 0;

   led_effect_seq #(.N_LEDS(N), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .stop_req  (stop_req),
      .mode      (mode),
      .period    (period),
      .leds      (leds),
      .busy      (busy),
      .done      (done),
      .step_tick (step_tick)
   );

   always #5 clk = ~clk;

   // Pattern shown after k steps, derived from the effect definitions.
   function automatic logic [N-1:0] pat(input int m, input int k);
      int pos;
      int ph;
      logic [N-1:0] one;
      one = 1;
      case (m)
         0: pat = (k < N) ? (one << k) : '0;
         1: pat = one << (k % N);
         2: begin
            ph  = k % (2*N - 2);
            pos = (ph < N) ? ph : (2*N - 2 - ph);
            pat = one << pos;
         end
         default: pat = (k < N) ? N'((1 << (k + 1)) - 1) : '0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [N-1:0] e_leds, input logic e_busy,
                          input logic e_done, input logic e_tick);
      chk({tag, ".leds"}, 32'(leds), 32'(e_leds));
      chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
      chk({tag, ".done"}, 32'(done), 32'(e_done));
      chk({tag, ".tick"}, 32'(step_tick), 32'(e_tick));
   endtask

   // Launch one effect and follow it to completion or abort at cycle stop_at
   // (cycle 0 is the first cycle showing the initial pattern).
   task automatic run(input int m, input int per, input int stop_at);
      int p;
      int k;
      int max_c;
      bit finite;
      bit tick_e;
      string ending;
      p      = (per == 0) ? 1 : per;
      finite = (m == 0) || (m == 3);
      max_c  = finite ? N*p + 1 : stop_at + 1;
      ending = "none";
      @(negedge clk);
      start  = 1'b1;
      mode   = 2'(m);
      period = CNT_W'(per);
      @(negedge clk);
      start  = 1'b0;
      for (int c = 0; c < max_c; c++) begin
         k      = c / p;
         tick_e = (c > 0) && (c % p == 0);
         if (finite && k == N) begin
            chk_out("complete", '0, 1'b0, 1'b1, 1'b1);
            ending = $sformatf("complete@%0d", c);
            break;
         end
         chk_out("run", pat(m, k), 1'b1, 1'b0, tick_e);
         if (c == stop_at) begin
            stop_req = 1'b1;
            @(negedge clk);
            stop_req = 1'b0;
            chk_out("abort", '0, 1'b0, 1'b1, 1'b0);
            ending = $sformatf("abort@%0d", c);
            break;
         end
         // Inputs that must be ignored while running.
         start  = 1'($urandom);
         mode   = 2'($urandom);
         period = CNT_W'($urandom_range(0, 5));
         @(negedge clk);
      end
      if (ending == "none") chk("ending_reached", 32'(0), 32'(1));
      start = 1'b1;   // ignored while in DONE
      @(negedge clk);
      start = 1'b0;
      chk_out("idle", '0, 1'b0, 1'b0, 1'b0);
      $display("run mode=%0d period=%0d stop_at=%0d -> %s", m, per, stop_at, ending);
   endtask

   initial begin
      int m;
      int per;
      int p;
      #1;
      chk_out("reset", '0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk_out("post_reset", '0, 1'b0, 1'b0, 1'b0);

      run(0, 3, -1);          // shift once, natural end at cycle 24
      run(1, 1, N + 2);       // rotate, abort while 04 shown after wrap
      run(2, 1, 20);          // bounce through both endpoints
      run(3, 2, -1);          // fill to all-ones then end
      run(0, 0, -1);          // period 0 behaves as 1
      run(1, 3, 2);           // abort coincident with a step
      run(3, 1, N - 1);       // abort while all-ones shown

      for (int r = 0; r < 24; r++) begin
         m   = $urandom_range(0, 3);
         per = $urandom_range(0, 4);
         p   = (per == 0) ? 1 : per;
         if (m == 0 || m == 3) run(m, per, $urandom_range(0, N*p + N*p/2));
         else                  run(m, per, $urandom_range(0, 40));
      end

      // Asynchronous reset in the middle of a rotate run, at pattern 10.
      @(negedge clk);
      start  = 1'b1;
      mode   = 2'd1;
      period = CNT_W'(1);
      @(negedge clk);
      start  = 1'b0;
      for (int c = 0; c < 5; c++) begin
         chk_out("pre_reset", pat(1, c), 1'b1, 1'b0, c > 0);
         if (c < 4) @(negedge clk);
      end
      #2 reset = 1'b1;
      #1 chk_out("async_reset", '0, 1'b0, 1'b0, 1'b0);
      $display("async reset asserted mid-run");
      @(negedge clk);
      reset = 1'b0;
      run(0, 1, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
